sum_res_norm: RTL and testbench

Downstream stage of the bfloat16 add/subtract datapath, fed directly by the mantissa alignment stage. It takes the larger operand's padded mantissa and the smaller operand's aligned mantissa, both 11 bits with 3 guard bits, and adds or subtracts them. It then normalizes the result, rounds to nearest-even and packs a bfloat16 word. It is a 2-stage elastic pipeline with a valid/ready handshake on both sides.

---
 rtl/sum_res_norm.sv | 126 ++++++++++++
 tb/tb_sum_res_norm.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/sum_res_norm.sv
// bfloat16 add/sub back end: mantissa add/subtract, then normalize, round-to-nearest-even
// and pack. Two-stage elastic pipeline with valid/ready on both sides.
module sum_res_norm (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic        sign_a_i,
  input  logic        sign_b_i,
  input  logic [7:0]  exp_i,
  input  logic [10:0] mant_a_i,
  input  logic [10:0] mant_b_i,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [15:0] result_o,
  output logic        overflow_o,
  output logic        zero_o
);

  logic        r_s1_valid;
  logic        r_s1_sign;
  logic [7:0]  r_s1_exp;
  logic [11:0] r_s1_sum;

  logic        r_valid;
  logic [15:0] r_result;
  logic        r_ovf;
  logic        r_zero;

  logic        w_s2_ready;
  logic        w_sub;
  logic        w_a_ge_b;
  logic [11:0] w_sum;

  assign w_s2_ready = !r_valid | ready_i;
  assign ready_o    = !r_s1_valid | w_s2_ready;
  assign w_sub      = sign_a_i ^ sign_b_i;
  assign w_a_ge_b   = mant_a_i >= mant_b_i;

  always_comb begin
    w_sum = {1'b0, mant_a_i} + {1'b0, mant_b_i};
    if (w_sub) begin
      w_sum = w_a_ge_b ? {1'b0, mant_a_i - mant_b_i} : {1'b0, mant_b_i - mant_a_i};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_s1_valid <= 1'b0;
      r_s1_sign  <= 1'b0;
      r_s1_exp   <= 8'h00;
      r_s1_sum   <= 12'h000;
    end else if (ready_o) begin
      r_s1_valid <= valid_i;
      if (valid_i) begin
        r_s1_sum  <= w_sum;
        r_s1_sign <= w_a_ge_b ? sign_a_i : sign_b_i;
        r_s1_exp  <= exp_i;
      end
    end
  end

  logic        w_carry;
  logic [3:0]  w_lz;
  logic [10:0] w_n;
  logic        w_sticky;
  logic [9:0]  w_e;
  logic        w_up;
  logic [7:0]  w_frac_rnd;
  logic [15:0] w_result;
  logic        w_ovf;
  logic        w_zero;

  always_comb begin
    // Upward scan: the last set bit seen is the MSB of s[10:0].
    w_lz = 4'd0;
    for (int i = 0; i <= 10; i++) begin
      if (r_s1_sum[i]) w_lz = 4'(10 - i);
    end
    w_carry  = r_s1_sum[11];
    w_n      = w_carry ? r_s1_sum[11:1] : (r_s1_sum[10:0] << w_lz);
    w_sticky = w_carry & r_s1_sum[0];
    w_e      = w_carry ? {2'b00, r_s1_exp} + 10'd1 : {2'b00, r_s1_exp} - {6'b0, w_lz};

    w_up       = w_n[2] & (w_n[1] | w_n[0] | w_sticky | w_n[3]);
    w_frac_rnd = {1'b0, w_n[9:3]} + {7'b0, w_up};
    // Fraction wrapped to zero; the hidden bit moves into the exponent.
    if (w_frac_rnd[7]) w_e = w_e + 10'd1;

    w_result = {r_s1_sign, w_e[7:0], w_frac_rnd[6:0]};
    w_ovf    = 1'b0;
    w_zero   = 1'b0;
    if (r_s1_sum == 12'h000) begin
      w_result = 16'h0000;
      w_zero   = 1'b1;
    end else if (!w_carry && (r_s1_exp <= {4'b0, w_lz})) begin
      w_result = {r_s1_sign, 15'h0000};
      w_zero   = 1'b1;
    end else if (w_e >= 10'd255) begin
      w_result = {r_s1_sign, 8'hFF, 7'h00};
      w_ovf    = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid  <= 1'b0;
      r_result <= 16'h0000;
      r_ovf    <= 1'b0;
      r_zero   <= 1'b0;
    end else if (w_s2_ready) begin
      r_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_result <= w_result;
        r_ovf    <= w_ovf;
        r_zero   <= w_zero;
      end
    end
  end

  assign valid_o    = r_valid;
  assign result_o   = r_result;
  assign overflow_o = r_ovf;
  assign zero_o     = r_zero;

endmodule

// File: tb/tb_sum_res_norm.sv
// Bench for sum_res_norm: directed vector table, backpressure and reset sequences,
// and random traffic scored against an arithmetic reference model.
module tb_sum_res_norm;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        valid_i;
  logic        ready_o;
  logic        sign_a_i;
  logic        sign_b_i;
  logic [7:0]  exp_i;
  logic [10:0] mant_a_i;
  logic [10:0] mant_b_i;
  logic        valid_o;
  logic        ready_i;
  logic [15:0] result_o;
  logic        overflow_o;
  logic        zero_o;

  sum_res_norm dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .valid_i    (valid_i),
    .ready_o    (ready_o),
    .sign_a_i   (sign_a_i),
    .sign_b_i   (sign_b_i),
    .exp_i      (exp_i),
    .mant_a_i   (mant_a_i),
    .mant_b_i   (mant_b_i),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .result_o   (result_o),
    .overflow_o (overflow_o),
    .zero_o     (zero_o)
  );

  always #5 clk_i = ~clk_i;

  int          n_vec = 0;
  int          n_err = 0;
  logic [17:0] expq[$];
  logic [17:0] held;
  bit          stall_prev = 1'b0;
  bit          saw_low = 1'b0;

  typedef struct {
    logic        sa;
    logic        sb;
    logic [7:0]  ex;
    logic [10:0] ma;
    logic [10:0] mb;
    logic [15:0] res;
    logic        ovf;
    logic        zero;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", name, act, req);
    end
  endtask

  // Returns {overflow, zero, result} from value arithmetic on the mantissas.
  function automatic logic [17:0] model(input logic sa, input logic sb, input logic [7:0] ex,
                                        input logic [10:0] ma, input logic [10:0] mb);
    int s, n, e, lz, keep, rem;
    bit sticky, carry, sgn, up;
    sgn = (ma >= mb) ? sa : sb;
    if (sa == sb) s = int'(ma) + int'(mb);
    else if (ma >= mb) s = int'(ma) - int'(mb);
    else s = int'(mb) - int'(ma);
    if (s == 0) return {1'b0, 1'b1, 16'h0000};
    e = ex;
    lz = 0;
    carry = s >= 2048;
    if (carry) begin
      sticky = s[0];
      n = s / 2;
      e = e + 1;
    end else begin
      sticky = 1'b0;
      n = s;
      while (n < 1024) begin
        n = n * 2;
        lz++;
      end
      e = e - lz;
    end
    if (!carry && int'(ex) <= lz) return {1'b0, 1'b1, sgn, 15'h0000};
    keep = n / 8;
    rem = n % 8;
    up = (rem > 4) || (rem == 4 && (sticky || (keep % 2 == 1)));
    keep = keep + int'(up);
    if (keep == 256) begin
      keep = 128;
      e = e + 1;
    end
    if (e >= 255) return {1'b1, 1'b0, sgn, 8'hFF, 7'h00};
    return {2'b00, sgn, e[7:0], keep[6:0]};
  endfunction

  task automatic rand_inputs();
    logic [10:0] tmp;
    sign_a_i = 1'($urandom);
    sign_b_i = 1'($urandom);
    exp_i    = 8'($urandom_range(11, 254));
    mant_a_i = {1'b1, 7'($urandom), 3'b000};
    tmp      = {1'b1, 7'($urandom), 3'b000};
    mant_b_i = tmp >> $urandom_range(0, 12);
    if ($urandom_range(0, 7) == 0) mant_b_i = mant_a_i;
  endtask

  // One cycle of scoreboarded traffic; handshakes are predicted at the falling edge.
  task automatic step(input bit drv_valid, input bit rdy);
    @(negedge clk_i);
    if (stall_prev) chk("hold_stable", {overflow_o, zero_o, result_o}, held);
    if (expq.size() == 0) chk("idle_valid_o", valid_o, 0);
    valid_i = drv_valid;
    ready_i = rdy;
    if (drv_valid) rand_inputs();
    #1;
    chk("ready_o", ready_o, !(expq.size() == 2 && !rdy));
    if (!ready_o) saw_low = 1'b1;
    if (valid_o && rdy) begin
      if (expq.size() == 0) chk("unexpected_out", 1, 0);
      else chk("result", {overflow_o, zero_o, result_o}, expq.pop_front());
    end
    if (valid_i && ready_o) expq.push_back(model(sign_a_i, sign_b_i, exp_i, mant_a_i, mant_b_i));
    stall_prev = valid_o && !rdy;
    held = {overflow_o, zero_o, result_o};
  endtask

  initial begin
    tbl[0]  = '{1'b0, 1'b0, 8'd127, 11'h400, 11'h400, 16'h4000, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 8'd128, 11'h400, 11'h300, 16'h3F00, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 8'd127, 11'h400, 11'h004, 16'h3F80, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 8'd127, 11'h408, 11'h004, 16'h3F82, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 8'd127, 11'h400, 11'h400, 16'h0000, 1'b0, 1'b1};
    tbl[5]  = '{1'b0, 1'b0, 8'd254, 11'h7F8, 11'h7F8, 16'h7F80, 1'b1, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 8'd2,   11'h400, 11'h3F8, 16'h8000, 1'b0, 1'b1};
    tbl[7]  = '{1'b0, 1'b0, 8'd127, 11'h7F8, 11'h004, 16'h4000, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 8'd127, 11'h300, 11'h400, 16'hBE80, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 8'd127, 11'h7F8, 11'h011, 16'h4001, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 8'd254, 11'h7F8, 11'h004, 16'h7F80, 1'b1, 1'b0};
    tbl[11] = '{1'b1, 1'b1, 8'd127, 11'h400, 11'h400, 16'hC000, 1'b0, 1'b0};

    rst_ni   = 1'b0;
    valid_i  = 1'b0;
    ready_i  = 1'b0;
    sign_a_i = 1'b0;
    sign_b_i = 1'b0;
    exp_i    = 8'h00;
    mant_a_i = 11'h000;
    mant_b_i = 11'h000;
    #12;
    chk("rst_valid_o", valid_o, 0);
    chk("rst_result_o", result_o, 0);
    chk("rst_flags", {overflow_o, zero_o}, 0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    #1;
    chk("rst_ready_o", ready_o, 1);

    // Directed vectors: accept edge, then valid_o after the following edge.
    for (int k = 0; k < 12; k++) begin
      @(negedge clk_i);
      valid_i  = 1'b1;
      ready_i  = 1'b1;
      sign_a_i = tbl[k].sa;
      sign_b_i = tbl[k].sb;
      exp_i    = tbl[k].ex;
      mant_a_i = tbl[k].ma;
      mant_b_i = tbl[k].mb;
      #1;
      chk("dir_ready_o", ready_o, 1);
      @(negedge clk_i);
      valid_i = 1'b0;
      chk("dir_latency_early", valid_o, 0);
      @(negedge clk_i);
      chk("dir_valid_o", valid_o, 1);
      chk($sformatf("dir_vec%0d", k), {overflow_o, zero_o, result_o},
          {tbl[k].ovf, tbl[k].zero, tbl[k].res});
    end

    // Backpressure: four back-to-back inputs with the sink stalled for four cycles.
    stall_prev = 1'b0;
    saw_low = 1'b0;
    step(1, 1);
    step(1, 0);
    step(1, 0);
    step(1, 0);
    step(0, 0);
    step(1, 1);
    for (int i = 0; i < 10 && expq.size() > 0; i++) step(0, 1);
    chk("bp_ready_fell", saw_low, 1);
    chk("bp_drained", expq.size(), 0);

    // Reset with two transactions in flight.
    step(1, 1);
    step(1, 0);
    step(0, 0);
    chk("pre_rst_inflight", expq.size(), 2);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("async_rst_valid_o", valid_o, 0);
    chk("async_rst_result_o", result_o, 0);
    expq.delete();
    stall_prev = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    for (int i = 0; i < 4; i++) step(0, 1);

    // Random traffic with random sink stalls.
    for (int i = 0; i < 400; i++) step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
    for (int i = 0; i < 10 && expq.size() > 0; i++) step(0, 1);
    chk("final_drain", expq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
